led_chaser_param: RTL
=====================

Name: led_chaser_param

Overview:
- Parametrised LED sequencer; next generation of the 8-LED right-shift chaser that blanks and repeats.
- Generalises width, step rate and blank length, and adds left shift, bounce and bar-fill modes, a run enable and a sequence-restart pulse.
- Drives a board LED bank directly.
- Sits at the top level next to the clock and reset pins.

Parameters:
- WIDTH, 8: number of LEDs; legal range 2..32.
- DIV, 1: clock cycles per step; legal range >=1. DIV=1 steps every enabled clock.
- BLANK_STEPS, 1: number of all-off steps at the end of a sweep, in SHIFT_R, SHIFT_L and FILL modes; legal range 0..15.

Ports:
- Clk, input, 1: clock, rising edge.
- RST_n, input, 1: reset, asynchronous, active-low.
- En, input, 1: run enable. When low, the prescaler and the pattern hold.
- Mode, input, 2: 00 SHIFT_R, 01 SHIFT_L, 10 BOUNCE, 11 FILL.
- LED, output, WIDTH: LED pattern; bit WIDTH-1 is the leftmost LED.
- Wrap, output, 1: 1-cycle pulse when a sequence restarts naturally.

Behaviour:
- Reset (RST_n=0, any time, takes effect immediately):
  - LED = one-hot MSB (8'b1000_0000 at WIDTH=8).
  - Wrap = 0, prescaler = 0, state = RUN, dir = right, blank count = 0, mode_q = 00.
- Prescaler:
  - Counter width is max(1, clog2(DIV)).
  - With En=1 it counts 0..DIV-1 and wraps. step = En and (cnt == DIV-1).
  - With En=0 the count holds.
  - All pattern updates happen only on step cycles. LED is registered and changes the cycle after the step condition.
- Mode sampling:
  - On each step, if Mode != mode_q: load the start pattern of the new Mode, set mode_q = Mode, state = RUN, blank count = 0, dir = right. Wrap stays 0.
  - Start pattern is one-hot LSB for SHIFT_L and one-hot MSB for all other modes.
  - Mode changes between steps have no effect until the next step.
- States: RUN, BLANK.
- SHIFT_R (RUN):
  - LED >>= 1 until LED == one-hot LSB.
  - At the next step from one-hot LSB: if BLANK_STEPS > 0, LED = 0 and state = BLANK; otherwise LED = MSB and Wrap = 1.
- SHIFT_L: mirror of SHIFT_R. Start at LSB, LED <<= 1, end at one-hot MSB, restart pattern is LSB.
- FILL (RUN):
  - LED = (LED >> 1) | MSB, giving 80, C0, E0, ... FF.
  - At the next step from all-ones: blank or restart, same rule as SHIFT_R.
- BLANK:
  - LED = 0 for exactly BLANK_STEPS steps, counted by the blank counter.
  - On the step that completes the count, LED = the mode's start pattern, state = RUN and Wrap = 1.
- BOUNCE:
  - One-hot; dir starts right.
  - At LSB, dir flips to left; at MSB while moving left, dir flips to right.
  - Never blanks.
  - Wrap = 1 on the step that reaches MSB while moving left.
  - Period is 2*(WIDTH-1) steps, so 14 at WIDTH=8.
- Wrap is asserted only in the single cycle after the restarting step; it is 0 at all other times.
- Simultaneous events:
  - Reset beats everything.
  - A mode change on a step beats natural sequence progression and suppresses Wrap.
  - En=0 on a would-be step cycle means no step happens.
- Robustness: if LED is ever 0 while in RUN, which is reachable only by a fault, the next step loads the start pattern.
- At the default parameters with Mode=00 and En=1, the output repeats 80, 40, 20, 10, 08, 04, 02, 01, 00, 80, ... and Wrap is high alongside the second 80.

Decomposition:
- Shared package led_pkg holds:
  - Mode encodings MODE_SHIFT_R, MODE_SHIFT_L, MODE_BOUNCE, MODE_FILL.
  - State encodings ST_RUN, ST_BLANK.
- One sub-module: led_tick_gen (parameter DIV; ports Clk, RST_n, En, step).
- All other logic stays in led_chaser_param.

Test Plan:
1. Default params, Mode=00, En=1, release reset → LED sequence 80, 40, 20, 10, 08, 04, 02, 01, 00, 80; Wrap high only with the second 80; period 9 clocks.
2. WIDTH=8, DIV=4, BLANK_STEPS=0, Mode=01 → LED starts at 80, changes to 01 at the first step (mode change, Wrap=0), then 02, 04, ... 80, 01; one change per 4 clocks; Wrap only on the 80→01 step.
3. Mode=10 → 80, 40, ... 01, 02, ... 80; Wrap once per 14 steps, never LED=0; then Mode=11 → 80, C0, E0, F0, F8, FC, FE, FF, 00, 80, with Wrap on the final 80.
4. En low for 10 clocks mid-sweep (LED=10) → LED and prescaler frozen; sequence resumes at 08 after En rises, with the prescaler phase preserved.
5. RST_n pulsed low between clock edges while in BLANK → LED = 80 immediately; after release, the state is RUN and the next step gives 40.
6. Mode switched 00→01 on a step that would have ended a SHIFT_R sweep (LED=01) → LED = 01 (the SHIFT_L start pattern), Wrap=0, no blank step, then 02 on the next step.

Source files
------------

// File: rtl/led_pkg.sv
// Shared encodings for the LED sequencer: display modes, sequencer states
// and bounce direction.
package led_pkg;

  localparam int unsigned MODE_W  = 2;
  localparam int unsigned BLANK_W = 4;

  typedef enum logic [MODE_W-1:0] {
    MODE_SHIFT_R = 2'b00,
    MODE_SHIFT_L = 2'b01,
    MODE_BOUNCE  = 2'b10,
    MODE_FILL    = 2'b11
  } mode_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_BLANK = 1'b1
  } state_e;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: produces a one-cycle step strobe every DIV enabled clocks.
// Ports: Clk, RST_n (async active-low), En (count enable), step (combinational
// strobe, high on the last count of each period while En is high).
module led_tick_gen
  import led_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic Clk,
  input  logic RST_n,
  input  logic En,
  output logic step
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running modulo-DIV counter, frozen while En is low.
  always_ff @(posedge Clk or negedge RST_n) begin
    if (!RST_n) begin
      cnt <= '0;
    end else if (En) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign step = En && (cnt == CNT_LAST);

endmodule

// File: rtl/led_chaser_param.sv
// Parametrised LED sequencer with right/left shift, bounce and bar-fill modes,
// optional blank steps between sweeps and a restart pulse.
// Ports: Clk, RST_n (async active-low), En (run enable), Mode (display mode),
// LED (registered pattern, bit WIDTH-1 leftmost), Wrap (registered one-cycle
// pulse after a natural sequence restart).
module led_chaser_param
  import led_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DIV         = 1,
  parameter int unsigned BLANK_STEPS = 1
) (
  input  logic             Clk,
  input  logic             RST_n,
  input  logic             En,
  input  logic [1:0]       Mode,
  output logic [WIDTH-1:0] LED,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0]   LED_LSB    = WIDTH'(1);
  localparam logic [WIDTH-1:0]   LED_MSB    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]   LED_ALL    = '1;
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_STEPS - 1);

  logic               step;
  mode_e              mode_in;
  logic [WIDTH-1:0]   led_q, led_d;
  logic [WIDTH-1:0]   led_shl, led_shr;
  logic               wrap_q, wrap_d;
  state_e             state_q, state_d;
  dir_e               dir_q, dir_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  mode_e              mode_q, mode_d;
  logic               sweep_end;
  logic               bounce_left;

  function automatic logic [WIDTH-1:0] start_pat(input mode_e m);
    return (m == MODE_SHIFT_L) ? LED_LSB : LED_MSB;
  endfunction

  led_tick_gen #(.DIV(DIV)) u_tick (
    .Clk  (Clk),
    .RST_n(RST_n),
    .En   (En),
    .step (step)
  );

  assign mode_in = mode_e'(Mode);
  assign led_shl = led_q << 1;
  assign led_shr = led_q >> 1;

  // Next-state: mode change wins over progression; progression only on steps.
  always_comb begin
    led_d       = led_q;
    wrap_d      = 1'b0;
    state_d     = state_q;
    dir_d       = dir_q;
    blank_d     = blank_q;
    mode_d      = mode_q;
    sweep_end   = 1'b0;
    bounce_left = 1'b0;
    if (step) begin
      if (mode_in != mode_q) begin
        led_d   = start_pat(mode_in);
        mode_d  = mode_in;
        state_d = ST_RUN;
        blank_d = '0;
        dir_d   = DIR_RIGHT;
      end else if (state_q == ST_BLANK) begin
        if (blank_q == BLANK_LAST) begin
          led_d   = start_pat(mode_q);
          state_d = ST_RUN;
          blank_d = '0;
          wrap_d  = 1'b1;
        end else begin
          blank_d = blank_q + BLANK_W'(1);
        end
      end else if (led_q == '0) begin
        // Dark pattern in RUN only arises from an upset; restart cleanly.
        led_d = start_pat(mode_q);
      end else begin
        unique case (mode_q)
          MODE_SHIFT_R: begin
            if (led_q == LED_LSB) sweep_end = 1'b1;
            else                  led_d     = led_shr;
          end
          MODE_SHIFT_L: begin
            if (led_q == LED_MSB) sweep_end = 1'b1;
            else                  led_d     = led_shl;
          end
          MODE_FILL: begin
            if (led_q == LED_ALL) sweep_end = 1'b1;
            else                  led_d     = led_shr | LED_MSB;
          end
          MODE_BOUNCE: begin
            // Turn around at the LSB; arriving back at the MSB ends a period.
            bounce_left = (dir_q == DIR_LEFT) || (led_q == LED_LSB);
            led_d       = bounce_left ? led_shl : led_shr;
            dir_d       = bounce_left ? DIR_LEFT : DIR_RIGHT;
            if (bounce_left && (led_shl == LED_MSB)) begin
              dir_d  = DIR_RIGHT;
              wrap_d = 1'b1;
            end
          end
        endcase
      end
      if (sweep_end) begin
        if (BLANK_STEPS > 0) begin
          led_d   = '0;
          state_d = ST_BLANK;
          blank_d = '0;
        end else begin
          led_d  = start_pat(mode_q);
          wrap_d = 1'b1;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge RST_n) begin
    if (!RST_n) begin
      led_q   <= LED_MSB;
      wrap_q  <= 1'b0;
      state_q <= ST_RUN;
      dir_q   <= DIR_RIGHT;
      blank_q <= '0;
      mode_q  <= MODE_SHIFT_R;
    end else begin
      led_q   <= led_d;
      wrap_q  <= wrap_d;
      state_q <= state_d;
      dir_q   <= dir_d;
      blank_q <= blank_d;
      mode_q  <= mode_d;
    end
  end

  assign LED  = led_q;
  assign Wrap = wrap_q;

endmodule
